// File: rtl/sdc_pkg.sv
// -----------------------------------------------------------------------------
// sdc_pkg
// Shared definitions for the SD-card SPI command engine.
//   - sdc_state_e : transaction phases of sdc_cmd_xfer
//   - frame / response widths
//   - common SD command indices used by the init and sector sequencers
//   - sdc_frame() : assembles the 48-bit command frame
// -----------------------------------------------------------------------------
package sdc_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        CMD  = 3'd2,
        POLL = 3'd3,
        RESP = 3'd4,
        POST = 3'd5,
        DONE = 3'd6
    } sdc_state_e;

    localparam int SDC_FRAME_W = 48;
    localparam int SDC_R1_W    = 8;
    localparam int SDC_R7_W    = 40;

    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD17  = 6'd17;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] ACMD41 = 6'd41;
    localparam logic [5:0] CMD58  = 6'd58;

    // Start bit 0, transmission bit 1, index, argument, CRC7, end bit 1.
    function automatic logic [SDC_FRAME_W-1:0] sdc_frame(
        input logic [5:0]  cmd,
        input logic [31:0] arg,
        input logic [6:0]  crc
    );
        return {2'b01, cmd, arg, crc, 1'b1};
    endfunction

endpackage

// File: rtl/sdc_sck_gen.sv
// -----------------------------------------------------------------------------
// sdc_sck_gen
// SPI mode-0 clock divider. While enabled, produces an SCK that is low for the
// first SCK_HALF cycles and high for the second SCK_HALF cycles of each bit
// period, plus strobes that are high during the cycle whose closing i_clk edge
// drives SCK high (o_rise) or low (o_fall). The first cycle after enable is a
// settle cycle, so every bit period starts one cycle after the FSM leaves IDLE.
// Ports:
//   i_clk, i_rst_n : system clock, async active-low reset
//   i_en           : run the divider; low clears it to the idle-low state
//   o_sck          : registered SPI clock
//   o_rise, o_fall : one-cycle edge strobes (combinational from registers)
// -----------------------------------------------------------------------------
module sdc_sck_gen #(
    parameter int SCK_HALF = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_sck,
    output logic o_rise,
    output logic o_fall
);

    localparam int DIV_W = $clog2(SCK_HALF);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_HALF - 1);

    logic [DIV_W-1:0] div_r;
    logic             phase_r;
    logic             armed_r;
    logic             wrap_s;

    // Half-period boundary: divider at its last count while running.
    always_comb begin
        wrap_s = i_en && armed_r && (div_r == DIV_LAST);
        o_rise = wrap_s && !phase_r;
        o_fall = wrap_s && phase_r;
    end

    assign o_sck = phase_r;

    // Divider counter and SCK phase; cleared whenever the divider is disabled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_r   <= '0;
            phase_r <= 1'b0;
            armed_r <= 1'b0;
        end else if (!i_en) begin
            div_r   <= '0;
            phase_r <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            armed_r <= 1'b1;
            if (armed_r) begin
                if (div_r == DIV_LAST) begin
                    div_r   <= '0;
                    phase_r <= ~phase_r;
                end else begin
                    div_r <= div_r + DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/sdc_cmd_xfer.sv
// -----------------------------------------------------------------------------
// sdc_cmd_xfer
// SD-card SPI command engine: sends optional 0xFF preamble bytes, the 48-bit
// command frame MSB first, polls MISO for the response start bit (bounded by
// NCR_MAX bytes), captures an R1 or R3/R7 response, clocks 8 turnaround bits
// and pulses o_done. CS may be left asserted for a following data phase.
// Parameters: SCK_HALF (cycles per SCK half), NCR_MAX (poll bytes),
//             PRE_BYTES (0xFF bytes ahead of the command)
// Ports:
//   i_clk, i_rst_n           : clock, async active-low reset
//   i_start                  : start request, honoured only in IDLE
//   i_cmd, i_arg, i_crc      : command fields
//   i_resp_long              : 0 = 8-bit R1, 1 = 40-bit R3/R7
//   i_keep_cs                : keep CS low after completion
//   i_miso                   : card data out
//   o_sck, o_mosi, o_cs_n    : SPI pins (mode 0, MOSI idles high)
//   o_busy, o_done           : transaction status, one-cycle completion
//   o_timeout, o_resp        : result, held until the next completion
// -----------------------------------------------------------------------------
module sdc_cmd_xfer
    import sdc_pkg::*;
#(
    parameter int SCK_HALF  = 4,
    parameter int NCR_MAX   = 8,
    parameter int PRE_BYTES = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [5:0]          i_cmd,
    input  logic [31:0]         i_arg,
    input  logic [6:0]          i_crc,
    input  logic                i_resp_long,
    input  logic                i_keep_cs,
    input  logic                i_miso,
    output logic                o_sck,
    output logic                o_mosi,
    output logic                o_cs_n,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_timeout,
    output logic [SDC_R7_W-1:0] o_resp
);

    localparam int POLL_BITS = NCR_MAX * 8;
    localparam int PRE_BITS  = PRE_BYTES * 8;
    localparam int MAX_A     = (POLL_BITS > SDC_FRAME_W) ? POLL_BITS : SDC_FRAME_W;
    localparam int MAX_BITS  = (MAX_A > PRE_BITS) ? MAX_A : PRE_BITS;
    localparam int CNT_W     = $clog2(MAX_BITS + 1);

    localparam logic [CNT_W-1:0] PRE_LAST  = (PRE_BYTES == 0) ? '0 : CNT_W'(PRE_BITS - 1);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(SDC_FRAME_W - 1);
    localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_BITS - 1);
    // The start bit is taken in POLL, so RESP counts only the remaining bits.
    localparam logic [CNT_W-1:0] R1_LAST   = CNT_W'(SDC_R1_W - 2);
    localparam logic [CNT_W-1:0] R7_LAST   = CNT_W'(SDC_R7_W - 2);
    localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(7);

    sdc_state_e                state_r;
    sdc_state_e                state_nx_s;
    logic [CNT_W-1:0]          cnt_r;
    logic [SDC_FRAME_W-1:0]    frame_r;
    logic [SDC_FRAME_W-1:0]    frame_s;
    logic [SDC_R7_W-1:0]       shift_r;
    logic [SDC_R7_W-1:0]       resp_r;
    logic [CNT_W-1:0]          resp_last_s;
    logic                      long_r;
    logic                      keep_r;
    logic                      sample_r;
    logic                      tmo_r;
    logic                      mosi_r;
    logic                      cs_n_r;
    logic                      busy_r;
    logic                      done_r;
    logic                      timeout_r;
    logic                      en_s;
    logic                      sck_s;
    logic                      rise_s;
    logic                      fall_s;

    // SCK runs in every phase that moves bits on the wire.
    always_comb begin
        en_s        = (state_r != IDLE) && (state_r != DONE);
        frame_s     = sdc_frame(i_cmd, i_arg, i_crc);
        resp_last_s = long_r ? R7_LAST : R1_LAST;
    end

    sdc_sck_gen #(
        .SCK_HALF (SCK_HALF)
    ) u_sck_gen (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (en_s),
        .o_sck   (sck_s),
        .o_rise  (rise_s),
        .o_fall  (fall_s)
    );

    // Next-state logic; phase changes happen only at bit-period ends (fall).
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_start) begin
                    state_nx_s = (PRE_BYTES == 0) ? CMD : PRE;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            PRE: begin
                if (fall_s && (cnt_r == PRE_LAST)) begin
                    state_nx_s = CMD;
                end else begin
                    state_nx_s = PRE;
                end
            end
            CMD: begin
                if (fall_s && (cnt_r == CMD_LAST)) begin
                    state_nx_s = POLL;
                end else begin
                    state_nx_s = CMD;
                end
            end
            POLL: begin
                if (fall_s) begin
                    if (!sample_r) begin
                        state_nx_s = RESP;
                    end else if (cnt_r == POLL_LAST) begin
                        state_nx_s = POST;
                    end else begin
                        state_nx_s = POLL;
                    end
                end else begin
                    state_nx_s = POLL;
                end
            end
            RESP: begin
                if (fall_s && (cnt_r == resp_last_s)) begin
                    state_nx_s = POST;
                end else begin
                    state_nx_s = RESP;
                end
            end
            POST: begin
                if (fall_s && (cnt_r == POST_LAST)) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = POST;
                end
            end
            DONE: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Bit counter: restarts on every phase change, advances per bit period.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r <= '0;
        end else if (state_nx_s != state_r) begin
            cnt_r <= '0;
        end else if (fall_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Datapath: frame shifting, MISO sampling and registered pin/status outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_r   <= '0;
            shift_r   <= '0;
            resp_r    <= '1;
            long_r    <= 1'b0;
            keep_r    <= 1'b0;
            sample_r  <= 1'b1;
            tmo_r     <= 1'b0;
            mosi_r    <= 1'b1;
            cs_n_r    <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (i_start) begin
                        frame_r  <= frame_s;
                        long_r   <= i_resp_long;
                        keep_r   <= i_keep_cs;
                        shift_r  <= '0;
                        sample_r <= 1'b1;
                        tmo_r    <= 1'b0;
                        cs_n_r   <= 1'b0;
                        busy_r   <= 1'b1;
                        mosi_r   <= (PRE_BYTES == 0) ? frame_s[SDC_FRAME_W-1] : 1'b1;
                    end
                end
                PRE: begin
                    if (state_nx_s == CMD) begin
                        mosi_r <= frame_r[SDC_FRAME_W-1];
                    end
                end
                CMD: begin
                    if (state_nx_s == POLL) begin
                        mosi_r <= 1'b1;
                    end else if (fall_s) begin
                        frame_r <= frame_r << 1;
                        mosi_r  <= frame_r[SDC_FRAME_W-2];
                    end
                end
                POLL: begin
                    if (rise_s) begin
                        sample_r <= i_miso;
                    end
                    if (state_nx_s == POST) begin
                        tmo_r <= 1'b1;
                    end
                end
                RESP: begin
                    // Start bit (0) is implied by the cleared upper bits.
                    if (rise_s) begin
                        shift_r <= {shift_r[SDC_R7_W-2:0], i_miso};
                    end
                end
                POST: begin
                    if (state_nx_s == DONE) begin
                        done_r    <= 1'b1;
                        busy_r    <= 1'b0;
                        timeout_r <= tmo_r;
                        resp_r    <= tmo_r ? '1 : shift_r;
                        cs_n_r    <= ~keep_r;
                    end
                end
                DONE: begin
                    mosi_r <= 1'b1;
                end
                default: begin
                    mosi_r <= 1'b1;
                end
            endcase
        end
    end

    assign o_sck     = sck_s;
    assign o_mosi    = mosi_r;
    assign o_cs_n    = cs_n_r;
    assign o_busy    = busy_r;
    assign o_done    = done_r;
    assign o_timeout = timeout_r;
    assign o_resp    = resp_r;

endmodule

// File: tb/tb_sdc_cmd_xfer.sv
// -----------------------------------------------------------------------------
// tb_sdc_cmd_xfer
// Scoreboard bench for sdc_cmd_xfer. Each issued command pushes its expected
// result (response, timeout, completion cycle, CS level, MOSI frame, SCK
// count) into a queue; an independent monitor pops and compares on o_done.
// A card model replays a bit stream (ones, response, ones) per SCK rise.
// -----------------------------------------------------------------------------
module tb_sdc_cmd_xfer;
    import sdc_pkg::*;

    localparam int H     = 2;
    localparam int NCR   = 8;
    localparam int PREB  = 1;
    localparam int HMASK = 32767;

    typedef struct {
        logic [39:0] resp;
        logic        tmo;
        longint      done_cyc;
        logic        cs_n;
        logic [47:0] frame;
        int          base;
        int          nbits;
    } exp_t;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic [5:0]  i_cmd;
    logic [31:0] i_arg;
    logic [6:0]  i_crc;
    logic        i_resp_long;
    logic        i_keep_cs;
    logic        i_miso = 1'b1;
    logic        o_sck;
    logic        o_mosi;
    logic        o_cs_n;
    logic        o_busy;
    logic        o_done;
    logic        o_timeout;
    logic [39:0] o_resp;

    int          n_tests = 0;
    int          n_fail  = 0;
    longint      cyc     = 0;
    int          rc      = 0;
    int          done_cnt = 0;
    bit          mosi_hist [0:HMASK];
    exp_t        sb_q [$];

    int          card_base = 0;
    int          card_p    = 0;
    int          card_len  = 8;
    logic [39:0] card_resp = '0;

    sdc_cmd_xfer #(
        .SCK_HALF  (H),
        .NCR_MAX   (NCR),
        .PRE_BYTES (PREB)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_cmd       (i_cmd),
        .i_arg       (i_arg),
        .i_crc       (i_crc),
        .i_resp_long (i_resp_long),
        .i_keep_cs   (i_keep_cs),
        .i_miso      (i_miso),
        .o_sck       (o_sck),
        .o_mosi      (o_mosi),
        .o_cs_n      (o_cs_n),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_timeout   (o_timeout),
        .o_resp      (o_resp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Card stream: bit idx (0-based SCK rise within the transaction).
    function automatic logic card_bit(input int idx);
        int j;
        j = idx - PREB * 8 - 48;
        if (j < card_p) return 1'b1;
        j = j - card_p;
        if (j < card_len) return card_resp[card_len - 1 - j];
        return 1'b1;
    endfunction

    // Record MOSI at every SCK rise and count rises.
    always @(posedge o_sck) begin
        mosi_hist[rc & HMASK] = o_mosi;
        rc = rc + 1;
    end

    // Card shifts its next bit out on SCK fall.
    always @(negedge o_sck) begin
        i_miso = card_bit(rc - card_base);
    end

    // Monitor: compare every completion against the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [47:0] got;
        int          idle_err;
        int          idx;
        if (i_rst_n === 1'b1 && o_done === 1'b1) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 64'(done_cnt), 64'(0));
            end else begin
                e = sb_q.pop_front();
                chk("resp", 64'(o_resp), 64'(e.resp));
                chk("timeout", 64'(o_timeout), 64'(e.tmo));
                chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
                chk("cs_at_done", 64'(o_cs_n), 64'(e.cs_n));
                chk("busy_at_done", 64'(o_busy), 64'(0));
                chk("sck_rises", 64'(rc - e.base), 64'(e.nbits));
                got = '0;
                idle_err = 0;
                for (int i = 0; i < e.nbits; i++) begin
                    idx = i - PREB * 8;
                    if (idx >= 0 && idx < 48) begin
                        got[47 - idx] = mosi_hist[(e.base + i) & HMASK];
                    end else if (mosi_hist[(e.base + i) & HMASK] != 1'b1) begin
                        idle_err++;
                    end
                end
                chk("mosi_frame", 64'(got), 64'(e.frame));
                chk("mosi_idle_ones", 64'(idle_err), 64'(0));
            end
        end
    end

    // Issue one command; push its expectation and wait for completion if asked.
    task automatic run_xfer(input logic [5:0] cmd, input logic [31:0] arg, input logic [6:0] crc,
                            input logic lng, input logic keep, input int p,
                            input logic [39:0] resp, input bit push, input int pulse_at);
        exp_t e;
        int   len;
        int   nb;
        int   d0;
        int   k;
        @(negedge clk);
        len = lng ? 40 : 8;
        card_base = rc;
        card_p    = p;
        card_len  = len;
        card_resp = resp;
        if (p >= NCR * 8) nb = PREB * 8 + 48 + NCR * 8 + 8;
        else              nb = PREB * 8 + 48 + p + len + 8;
        e.resp     = (p >= NCR * 8) ? 40'hFF_FFFF_FFFF : (lng ? resp : {32'h0, resp[7:0]});
        e.tmo      = (p >= NCR * 8);
        e.done_cyc = cyc + 2 + longint'(nb * 2 * H);
        e.cs_n     = ~keep;
        e.frame    = {2'b01, cmd, arg, crc, 1'b1};
        e.base     = rc;
        e.nbits    = nb;
        if (push) sb_q.push_back(e);
        d0          = done_cnt;
        i_cmd       = cmd;
        i_arg       = arg;
        i_crc       = crc;
        i_resp_long = lng;
        i_keep_cs   = keep;
        i_start     = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("cs_fall", 64'(o_cs_n), 64'(0));
        chk("busy_on", 64'(o_busy), 64'(1));
        if (push) begin
            k = 0;
            while (k < nb * 2 * H + 50 && done_cnt == d0) begin
                i_start = (k == pulse_at) ? 1'b1 : 1'b0;
                @(negedge clk);
                k++;
            end
            i_start = 1'b0;
            chk("done_seen", 64'(done_cnt - d0), 64'(1));
        end
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [39:0] r;
        logic [5:0]  c;
        logic        lng;
        int          b;
        int          d0;
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_cmd = '0; i_arg = '0; i_crc = '0; i_resp_long = 1'b0; i_keep_cs = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sck", 64'(o_sck), 64'(0));
        chk("rst_mosi", 64'(o_mosi), 64'(1));
        chk("rst_cs_n", 64'(o_cs_n), 64'(1));
        chk("rst_busy", 64'(o_busy), 64'(0));
        chk("rst_done", 64'(o_done), 64'(0));
        chk("rst_timeout", 64'(o_timeout), 64'(0));
        chk("rst_resp", 64'(o_resp), 64'(40'hFF_FFFF_FFFF));
        i_rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // CMD0, R1 0x01 after two poll bytes.
        run_xfer(CMD0, 32'h0, 7'h4A, 1'b0, 1'b0, 16, 40'h01, 1'b1, -1);
        // CMD8 long response.
        run_xfer(CMD8, 32'h1AA, 7'h43, 1'b1, 1'b0, 5, 40'h01_0000_01AA, 1'b1, -1);
        // Timeout: MISO stays high.
        run_xfer(CMD58, 32'h0, 7'h7E, 1'b0, 1'b0, 1000, 40'h0, 1'b1, -1);
        chk("cs_after_timeout", 64'(o_cs_n), 64'(1));
        // Keep CS across CMD17, release after CMD13.
        run_xfer(CMD17, 32'h0000_0200, 7'h2A, 1'b0, 1'b1, 3, 40'h00, 1'b1, -1);
        repeat (5) @(negedge clk);
        chk("cs_held_idle", 64'(o_cs_n), 64'(0));
        run_xfer(6'd13, 32'h0, 7'h06, 1'b0, 1'b0, 0, 40'h00, 1'b1, -1);
        repeat (3) @(negedge clk);
        chk("cs_released", 64'(o_cs_n), 64'(1));

        // Reset during the command frame.
        b = rc;
        run_xfer(CMD0, 32'h0, 7'h4A, 1'b0, 1'b0, 16, 40'h01, 1'b0, -1);
        for (int k = 0; k < 4000 && (rc - b) < PREB * 8 + 20; k++) @(posedge clk);
        chk("reached_bit20", 64'(rc - b), 64'(PREB * 8 + 20));
        #1 i_rst_n = 1'b0;
        #1;
        chk("mid_rst_cs_n", 64'(o_cs_n), 64'(1));
        chk("mid_rst_sck", 64'(o_sck), 64'(0));
        chk("mid_rst_mosi", 64'(o_mosi), 64'(1));
        chk("mid_rst_busy", 64'(o_busy), 64'(0));
        repeat (3) @(negedge clk);
        i_rst_n = 1'b1;
        run_xfer(CMD0, 32'h0, 7'h4A, 1'b0, 1'b0, 16, 40'h01, 1'b1, -1);

        // Start pulse during POLL must be ignored.
        d0 = done_cnt;
        run_xfer(CMD55, 32'h0, 7'h32, 1'b0, 1'b0, 16, 40'h01, 1'b1, 240);
        repeat (400) @(negedge clk);
        chk("busy_rule_single_done", 64'(done_cnt - d0), 64'(1));

        // Randomised commands.
        for (int t = 0; t < 16; t++) begin
            c   = 6'($urandom_range(0, 63));
            lng = 1'($urandom_range(0, 1));
            r   = {8'($urandom), $urandom};
            if (lng) r[39] = 1'b0;
            else     r = {32'h0, 1'b0, r[6:0]};
            run_xfer(c, $urandom, 7'($urandom_range(0, 127)), lng,
                     1'($urandom_range(0, 1)), int'($urandom_range(0, 70)), r, 1'b1, -1);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
